// File: rtl/invsqrt_pkg.sv
// Shared definitions for the Newton-Raphson inverse square root block:
// controller states and fixed-point constants derived from the fraction width.
package invsqrt_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      MUL_YY = 3'd1,
      MUL_HT = 3'd2,
      MUL_YT = 3'd3,
      DONE   = 3'd4
   } state_t;

   // 1.5 in Q(.fw): binary 1.1 followed by zeros
   function automatic logic [63:0] three_halves(input int unsigned fw);
      return 64'd3 << (fw - 1);
   endfunction

   // Half an LSB of the fraction, added before truncation for round-half-up
   function automatic logic [63:0] round_const(input int unsigned fw);
      return 64'd1 << (fw - 1);
   endfunction

endpackage

// File: rtl/inv_sqrt_newton_fix_mul.sv
// Unsigned fixed-point W x W multiplier: full product, round-half-up at the
// fraction boundary, saturate to all ones when the result overflows W bits.
module fix_mul
   import invsqrt_pkg::*;
#(
   parameter int W  = 16,
   parameter int FW = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] p
);

   localparam logic [2*W:0] RND = (2*W+1)'(round_const(FW));

   logic [2*W-1:0] prod;
   logic [2*W:0]   prod_rnd;
   logic [2*W:0]   shifted;

   function automatic logic [W-1:0] sat(input logic [2*W:0] v);
      return (|v[2*W:W]) ? {W{1'b1}} : v[W-1:0];
   endfunction

   assign prod     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
   assign prod_rnd = {1'b0, prod} + RND;
   assign shifted  = prod_rnd >> FW;
   assign p        = sat(shifted);

endmodule

// File: rtl/inv_sqrt_newton.sv
// Iterative 1/sqrt(x) refinement: y <- y*(1.5 - (x/2)*y*y), one multiply per
// cycle through a single shared multiplier, valid/ready on both sides.
module inv_sqrt_newton
   import invsqrt_pkg::*;
#(
   parameter int INT_WIDTH   = 8,
   parameter int FRACT_WIDTH = 8,
   parameter int ITERATIONS  = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [INT_WIDTH+FRACT_WIDTH-1:0] x_fix,
   input  logic [INT_WIDTH+FRACT_WIDTH-1:0] y0_fix,
   input  logic                             in_valid,
   output logic                             in_ready,
   output logic [INT_WIDTH+FRACT_WIDTH-1:0] y_fix,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             out_zero
);

   localparam int W = INT_WIDTH + FRACT_WIDTH;
   localparam logic [W-1:0] THREE_HALVES = W'(three_halves(FRACT_WIDTH));
   localparam logic [1:0]   LAST_PASS    = 2'(ITERATIONS - 1);

   state_t         state;
   logic [1:0]     iter_cnt;
   logic [W-1:0]   x_r;
   logic [W-1:0]   y_r;
   logic [W-1:0]   t_r;
   logic           zero_r;
   logic [W-1:0]   corr;
   logic [W-1:0]   mul_a;
   logic [W-1:0]   mul_b;
   logic [W-1:0]   mul_p;

   // 1.5 - t, clamped so a huge t cannot wrap into a large positive factor
   assign corr     = (t_r > THREE_HALVES) ? '0 : THREE_HALVES - t_r;
   assign in_ready = (state == IDLE);

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state)
         MUL_YY: begin
            mul_a = y_r;
            mul_b = y_r;
         end
         MUL_HT: begin
            mul_a = x_r >> 1;
            mul_b = t_r;
         end
         MUL_YT: begin
            mul_a = y_r;
            mul_b = corr;
         end
         default: ;
      endcase
   end

   fix_mul #(
      .W  (W),
      .FW (FRACT_WIDTH)
   ) u_mul (
      .a (mul_a),
      .b (mul_b),
      .p (mul_p)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         iter_cnt  <= 2'd0;
         y_fix     <= '0;
         out_valid <= 1'b0;
         out_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_r      <= x_fix;
                  y_r      <= y0_fix;
                  zero_r   <= (x_fix == '0);
                  iter_cnt <= 2'd0;
                  state    <= MUL_YY;
               end
            end
            MUL_YY: begin
               t_r   <= mul_p;
               state <= MUL_HT;
            end
            MUL_HT: begin
               t_r   <= mul_p;
               state <= MUL_YT;
            end
            MUL_YT: begin
               y_r <= mul_p;
               if (iter_cnt == LAST_PASS) begin
                  y_fix     <= mul_p;
                  out_zero  <= zero_r;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  iter_cnt <= iter_cnt + 2'd1;
                  state    <= MUL_YY;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_sqrt_newton.sv
// Directed bench for inv_sqrt_newton in Q8.8: one instance with a single pass,
// one with two passes, hand-computed results and cycle-exact latencies.
module tb_inv_sqrt_newton;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] x_fix, y0_fix;
   logic        in_valid, in_valid2;
   logic        out_ready;
   logic        in_ready, out_valid, out_zero;
   logic [15:0] y_fix;
   logic        in_ready2, out_valid2, out_zero2;
   logic [15:0] y_fix2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inv_sqrt_newton #(.INT_WIDTH(8), .FRACT_WIDTH(8), .ITERATIONS(1)) dut (
      .clk(clk), .rst_n(rst_n), .x_fix(x_fix), .y0_fix(y0_fix),
      .in_valid(in_valid), .in_ready(in_ready), .y_fix(y_fix),
      .out_valid(out_valid), .out_ready(out_ready), .out_zero(out_zero)
   );

   inv_sqrt_newton #(.INT_WIDTH(8), .FRACT_WIDTH(8), .ITERATIONS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .x_fix(x_fix), .y0_fix(y0_fix),
      .in_valid(in_valid2), .in_ready(in_ready2), .y_fix(y_fix2),
      .out_valid(out_valid2), .out_ready(out_ready), .out_zero(out_zero2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operand to the single-pass instance for one accepting edge
   task automatic accept(input logic [15:0] x, input logic [15:0] y0);
      x_fix    = x;
      y0_fix   = y0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Ticks until out_valid of the single-pass instance, bounded
   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
   endtask

   int n;

   initial begin
      rst_n = 1'b0; x_fix = '0; y0_fix = '0;
      in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
      tick(); tick();
      chk("rst_y", y_fix, 16'h0000);
      chk("rst_ov", out_valid, 1'b0);
      chk("rst_oz", out_zero, 1'b0);
      chk("rst_ir", in_ready, 1'b1);
      rst_n = 1'b1;
      tick();

      // Identity: x=1.0, y0=1.0
      accept(16'h0100, 16'h0100);
      chk("id_ir_busy", in_ready, 1'b0);
      wait_out(n);
      chk("id_lat", n, 3);
      chk("id_y", y_fix, 16'h0100);
      chk("id_oz", out_zero, 1'b0);
      tick();
      chk("id_back_idle", in_ready, 1'b1);

      // Two-pass instance, same operand
      x_fix = 16'h0100; y0_fix = 16'h0100; in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      n = 0;
      while (!out_valid2 && n < 20) begin
         tick();
         n++;
      end
      chk("it2_lat", n, 6);
      chk("it2_y", y_fix2, 16'h0100);
      tick();

      // x=4.0, y0=0.375: watch the intermediates stage by stage
      accept(16'h0400, 16'h0060);
      tick();
      chk("x4_yy", dut.t_r, 16'h0024);
      tick();
      chk("x4_ht", dut.t_r, 16'h0048);
      chk("x4_corr", dut.corr, 16'h0138);
      chk("x4_ov_early", out_valid, 1'b0);
      tick();
      chk("x4_ov", out_valid, 1'b1);
      chk("x4_y", y_fix, 16'h0075);
      tick();

      // Saturation and clamp
      accept(16'hFFFF, 16'hFFFF);
      tick();
      chk("sat_yy", dut.t_r, 16'hFFFF);
      tick();
      chk("sat_corr", dut.corr, 16'h0000);
      tick();
      chk("sat_y", y_fix, 16'h0000);
      tick();

      // Zero operand still computes, flags out_zero
      accept(16'h0000, 16'h0100);
      wait_out(n);
      chk("zero_lat", n, 3);
      chk("zero_y", y_fix, 16'h0180);
      chk("zero_oz", out_zero, 1'b1);
      tick();

      // Backpressure in DONE with a stray operand offered
      out_ready = 1'b0;
      accept(16'h0400, 16'h0060);
      wait_out(n);
      chk("bp_lat", n, 3);
      x_fix = 16'h0100; y0_fix = 16'h0100; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_ov", out_valid, 1'b1);
         chk("bp_y", y_fix, 16'h0075);
         chk("bp_ir", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_hs_ov", out_valid, 1'b0);
      chk("bp_hs_idle", dut.state, 32'(invsqrt_pkg::IDLE));
      in_valid = 1'b0;
      tick();
      chk("bp_still_idle", dut.state, 32'(invsqrt_pkg::IDLE));

      // Reset while in MUL_HT abandons the operation
      accept(16'h0400, 16'h0060);
      tick();
      chk("rmid_state", dut.state, 32'(invsqrt_pkg::MUL_HT));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rmid_idle", dut.state, 32'(invsqrt_pkg::IDLE));
      chk("rmid_ov", out_valid, 1'b0);
      chk("rmid_ir", in_ready, 1'b1);
      chk("rmid_y", y_fix, 16'h0000);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (out_valid) n++;
      end
      chk("rmid_no_out", n, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
